// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by seq_alu and ALU control.
// Build option SEQ_ALU_BARREL_EN selects single-cycle shifting in seq_alu.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_SLL = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_OR  = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_BEQ = 4'b0111;
   localparam logic [3:0] ALU_BNE = 4'b1000;
   localparam logic [3:0] ALU_BLT = 4'b1001;
   localparam logic [3:0] ALU_BGE = 4'b1010;
   localparam logic [3:0] ALU_NOP = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response handshake bundle between datapath and seq_alu.
// Master issues operations and consumes results; slave is the ALU.
interface seq_alu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_in_1;
   logic [XLEN-1:0] alu_in_2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_result;
   logic            alu_bcond;

   modport master (
      output in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
      input  in_ready, out_valid, alu_result, alu_bcond
   );

   modport slave (
      input  in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
      output in_ready, out_valid, alu_result, alu_bcond
   );
endinterface

// File: rtl/seq_alu_shifter.sv
// seq_alu_shifter: iterative one-bit-per-cycle logical shifter.
// done_o fires on the last step; result_o then carries the final value.
module seq_alu_shifter #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic               left_i,
   input  logic [XLEN-1:0]    a_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic               done_o,
   output logic [XLEN-1:0]    result_o
);
   logic [XLEN-1:0]    work_q, work_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               busy_q, busy_d;
   logic [XLEN-1:0]    step;

   assign step = left_q ? {work_q[XLEN-2:0], 1'b0}
                        : {1'b0, work_q[XLEN-1:1]};

   // The copy-out happens on the edge where the counter hits zero.
   assign done_o   = busy_q && (cnt_q == SHAMT_W'(1));
   assign result_o = step;

   // Load on start, otherwise shift and count down while busy.
   always_comb begin
      work_d = work_q;
      cnt_d  = cnt_q;
      left_d = left_q;
      busy_d = busy_q;
      if (start_i) begin
         work_d = a_i;
         cnt_d  = shamt_i;
         left_d = left_i;
         busy_d = 1'b1;
      end else if (busy_q) begin
         work_d = step;
         cnt_d  = cnt_q - SHAMT_W'(1);
         if (cnt_q == SHAMT_W'(1)) busy_d = 1'b0;
      end
   end

   // Working state; reset discards any shift in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         work_q <= '0;
         cnt_q  <= '0;
         left_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         left_q <= left_d;
         busy_q <= busy_d;
      end
   end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshake and branch flag.
// Define SEQ_ALU_BARREL_EN for single-cycle shifts (no SHIFT state used).
module seq_alu
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input logic      clk,
   input logic      reset,
   seq_alu_if.slave bus
);
   state_e             state_q, state_d;
   logic [XLEN-1:0]    result_q, result_d;
   logic               bcond_q, bcond_d;
   logic [XLEN-1:0]    a, b;
   logic [3:0]         op;
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]    alu_res;
   logic               alu_bc;
   logic               accept;
   logic [XLEN-1:0]    sh_res;

   assign a      = bus.alu_in_1;
   assign b      = bus.alu_in_2;
   assign op     = bus.alu_op;
   assign shamt  = b[SHAMT_W-1:0];
   assign accept = bus.in_valid && (state_q == ST_IDLE);

`ifdef SEQ_ALU_BARREL_EN
   assign sh_res = (op == ALU_SLL) ? (a << shamt) : (a >> shamt);
`else
   logic sh_start;
   logic sh_done;

   seq_alu_shifter #(
      .XLEN    (XLEN),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .clk      (clk),
      .reset    (reset),
      .start_i  (sh_start),
      .left_i   (op == ALU_SLL),
      .a_i      (a),
      .shamt_i  (shamt),
      .done_o   (sh_done),
      .result_o (sh_res)
   );
`endif

   // Single-cycle ops on the live operands; shifts/invalid give zero.
   always_comb begin
      alu_res = '0;
      alu_bc  = 1'b0;
      case (op)
         ALU_ADD: alu_res = a + b;
         ALU_SUB: alu_res = a - b;
         ALU_XOR: alu_res = a ^ b;
         ALU_OR:  alu_res = a | b;
         ALU_AND: alu_res = a & b;
         ALU_BEQ: alu_bc  = (a == b);
         ALU_BNE: alu_bc  = (a != b);
         ALU_BLT: alu_bc  = ($signed(a) < $signed(b));
         ALU_BGE: alu_bc  = ($signed(a) >= $signed(b));
         default: ;
      endcase
   end

   // Control FSM: accept in IDLE, iterate in SHIFT, hold result in DONE.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      bcond_d  = bcond_q;
`ifndef SEQ_ALU_BARREL_EN
      sh_start = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = ST_DONE;
               result_d = alu_res;
               bcond_d  = alu_bc;
               if (is_shift(op)) begin
`ifdef SEQ_ALU_BARREL_EN
                  result_d = sh_res;
`else
                  if (shamt == '0) begin
                     result_d = a;
                  end else begin
                     state_d  = ST_SHIFT;
                     sh_start = 1'b1;
                  end
`endif
               end
            end
         end
         ST_SHIFT: begin
`ifdef SEQ_ALU_BARREL_EN
            state_d = ST_IDLE;
`else
            if (sh_done) begin
               result_d = sh_res;
               state_d  = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         bcond_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         bcond_q  <= bcond_d;
      end
   end

   assign bus.in_ready   = (state_q == ST_IDLE);
   assign bus.out_valid  = (state_q == ST_DONE);
   assign bus.alu_result = result_q;
   assign bus.alu_bcond  = bcond_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with a scoreboard queue and decoupled monitor.
// Latency expectations follow SEQ_ALU_BARREL_EN when it is defined.
module tb_seq_alu;
   import alu_pkg::*;

`ifdef SEQ_ALU_BARREL_EN
   localparam int L31 = 1;
   localparam int L4  = 1;
   localparam int L3  = 1;
`else
   localparam int L31 = 32;
   localparam int L4  = 5;
   localparam int L3  = 4;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   seq_alu_if #(.XLEN(32)) bus ();

   seq_alu #(
      .XLEN    (32),
      .SHAMT_W (5)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        bc;
      int          lat;
      int          acc;
      string       name;
   } exp_t;

   exp_t sbq[$];
   exp_t cur;
   logic prev_ov = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Monitor: pop on each new result, then check it stays stable.
   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (!prev_ov) begin
            if (sbq.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL spurious_out: got %h, want no output",
                        bus.alu_result);
            end else begin
               cur = sbq.pop_front();
               chk({cur.name, "_res"}, bus.alu_result, cur.res);
               chk({cur.name, "_bcond"}, 32'(bus.alu_bcond), 32'(cur.bc));
               chk({cur.name, "_lat"}, 32'(cyc - cur.acc), 32'(cur.lat));
            end
         end else begin
            chk({cur.name, "_hold_res"}, bus.alu_result, cur.res);
            chk({cur.name, "_hold_bc"}, 32'(bus.alu_bcond), 32'(cur.bc));
         end
      end
      prev_ov = bus.out_valid;
   end

   task automatic issue(input string nm, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eb,
                        input int lat, input bit expect_out);
      int w;
      exp_t e;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) begin
         checks++;
         fails++;
         $display("FAIL %s_issue_timeout: in_ready %b, want 1",
                  nm, bus.in_ready);
         return;
      end
      bus.in_valid = 1'b1;
      bus.alu_op   = op;
      bus.alu_in_1 = a;
      bus.alu_in_2 = b;
      if (expect_out) begin
         e.res  = er;
         e.bc   = eb;
         e.lat  = lat;
         e.acc  = cyc;
         e.name = nm;
         sbq.push_back(e);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.alu_in_1 = 32'hDEAD_BEEF;
      bus.alu_in_2 = 32'h0000_0013;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((sbq.size() != 0 || bus.out_valid) && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: pending %0d, want 0", sbq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.in_valid  = 1'b0;
      bus.alu_op    = ALU_ADD;
      bus.alu_in_1  = '0;
      bus.alu_in_2  = '0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.alu_result, 32'd0);
      chk("rst_bcond", 32'(bus.alu_bcond), 32'd0);
      rst_n = 1'b1;

      issue("add", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 1);
      issue("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 1, 1);
      issue("sub0", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 1, 1);
      issue("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00,
            32'h0FF0_0FF0, 0, 1, 1);
      issue("or", ALU_OR, 32'h0F0F_0000, 32'h0000_00F0,
            32'h0F0F_00F0, 0, 1, 1);
      issue("and", ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F,
            32'h0F0F_0000, 0, 1, 1);
      drain();

      issue("sll31", ALU_SLL, 32'h1, 32'd31, 32'h8000_0000, 0, L31, 1);
      k = 0;
      while (!bus.out_valid && k < 40) begin
         chk("sll_busy_in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
         k++;
      end
      drain();

      issue("srl0", ALU_SRL, 32'h8000_0000, 32'd0, 32'h8000_0000, 0, 1, 1);
      issue("srl4", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, L4, 1);
      issue("sll3", ALU_SLL, 32'h3, 32'h23, 32'h18, 0, L3, 1);
      issue("blt", ALU_BLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1, 1);
      issue("bge", ALU_BGE, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, 1);
      issue("beq", ALU_BEQ, 32'h1234, 32'h1234, 32'h0, 1, 1, 1);
      issue("bne", ALU_BNE, 32'h1234, 32'h1234, 32'h0, 0, 1, 1);
      issue("nop", ALU_NOP, 32'h5, 32'h6, 32'h0, 0, 1, 1);
      issue("inv", 4'b1100, 32'h5, 32'h6, 32'h0, 0, 1, 1);
      drain();

      bus.out_ready = 1'b0;
      issue("hold", ALU_ADD, 32'd5, 32'd6, 32'd11, 0, 1, 1);
      k = 0;
      while (!bus.out_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      bus.in_valid = 1'b1;
      bus.alu_op   = ALU_SUB;
      bus.alu_in_1 = 32'd100;
      bus.alu_in_2 = 32'd1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("release_out_valid", 32'(bus.out_valid), 32'd0);
      chk("release_in_ready", 32'(bus.in_ready), 32'd1);

`ifndef SEQ_ALU_BARREL_EN
      issue("abort", ALU_SLL, 32'h1, 32'd10, 32'h400, 0, 11, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_result", bus.alu_result, 32'd0);
      rst_n = 1'b1;
      repeat (15) begin
         @(negedge clk);
         chk("abort_no_out", 32'(bus.out_valid), 32'd0);
      end
`endif

      issue("post", ALU_ADD, 32'd1, 32'd2, 32'd3, 0, 1, 1);
      drain();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end
endmodule
